ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Counterpart of the PS/2 receive path; shares the open-drain PS2_clk/PS2_dat lines with it.
//  Runs the full host request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ACK.
//  busy gates the receiver so it ignores frames while a transmission is in progress.
// PARAMETERS
//  INHIBIT_CYCLES  12000      clk cycles PS2_clk is held low before request (120 us @ 100 MHz)
//  TIMEOUT_CYCLES  1500000    watchdog from clock release to ACK sample (15 ms @ 100 MHz)
//  FILTER_LEN      8          consecutive equal samples required for a filtered PS2_clk change
// PORTS
//  clk            in   1  system clock (100 MHz)
//  reset          in   1  synchronous, active-high reset
//  tx_data        in   8  command byte to send
//  tx_valid       in   1  request; accepted when tx_valid && tx_ready
//  tx_ready       out  1  1 only in IDLE
//  ps2_clk_in     in   1  raw PS2_clk line level (asynchronous)
//  ps2_dat_in     in   1  raw PS2_dat line level (asynchronous)
//  ps2_clk_low    out  1  1 = drive PS2_clk low, 0 = release (pad is open-drain)
//  ps2_dat_low    out  1  1 = drive PS2_dat low, 0 = release
//  busy           out  1  1 in every state except IDLE
//  done           out  1  one-cycle pulse at end of transaction
//  ack_err        out  1  valid with done: 1 = device did not pull PS2_dat low on ACK bit
//  timeout        out  1  valid with done: 1 = watchdog expired; ack_err is 0 in this case
// BEHAVIOUR
//  Reset: state IDLE; tx_ready=1; busy, done, ack_err, timeout, ps2_clk_low, ps2_dat_low = 0; counters and filter cleared (filtered clock = 1).
//  Reset mid-frame: both lines released on the next cycle, no done pulse; reset wins over tx_valid in the same cycle.
//  Input path: 2-FF synchroniser on each line. PS2_clk filter changes only after FILTER_LEN consecutive equal samples.
//   fall = filtered clock 1->0, a single-cycle strobe.
//  Accept: tx_valid && tx_ready latches tx_data and parity = ~^tx_data, then enters INHIBIT.
//   tx_ready=0 and busy=1 from the next cycle. tx_valid outside IDLE is ignored.
//  FSM:
//   IDLE     -> INHIBIT on accept.
//   INHIBIT  ps2_clk_low=1 for INHIBIT_CYCLES cycles; ps2_dat_low=1 on the last of them (start bit) -> REQ.
//   REQ      ps2_clk_low=0, ps2_dat_low=1; bit index n=0; watchdog starts -> SHIFT.
//   SHIFT    on each fall, n increments and the line is updated in the same cycle:
//             n=1..8: ps2_dat_low = ~tx_data[n-1]
//             n=9:    ps2_dat_low = ~parity
//             n=10:   ps2_dat_low = 0 (stop)
//             n=11:   sample synced PS2_dat, ack_err = dat, then -> WAIT_IDLE.
//   WAIT_IDLE both synced lines high -> DONE.
//   DONE     done=1 for one cycle with ack_err/timeout -> IDLE.
//  Watchdog: counts every cycle from REQ until the n=11 sample. Reaching TIMEOUT_CYCLES releases both lines,
//   sets timeout=1, ack_err=0 and goes to DONE, skipping WAIT_IDLE.
//  The host never drives PS2_clk outside INHIBIT. ps2_dat_low is registered.
//  Glitches shorter than FILTER_LEN cycles never advance n.
//  Latency: accept to start bit = INHIBIT_CYCLES cycles; the frame itself is paced by the device (about 1 ms at 11 kHz).
// TESTING
//  1 Send 0xED, device model clocks at 12.5 kHz and ACKs -> bits 1,0,1,1,0,1,1,1 then parity 1, stop 1; done, ack_err=0, timeout=0.
//  2 Send 0x01 and 0xFF -> parity bits 0 and 1 respectively; INHIBIT holds PS2_clk low for exactly 12000 cycles.
//  3 Device clocks but leaves PS2_dat high on the ACK bit -> done with ack_err=1; lines released.
//  4 Device never clocks -> done with timeout=1 exactly 1500000 cycles after REQ; ps2_clk_low=ps2_dat_low=0.
//  5 Assert reset after the 4th data bit -> next cycle IDLE, tx_ready=1, lines released, no done; a new 0xF4 send then completes.
//  6 Inject 3-cycle PS2_clk low glitches during SHIFT -> bit count unaffected. Pulse tx_valid while busy -> ignored.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device: clock inhibit, start bit, 8 data bits
// LSB first, odd parity, stop bit, then samples the device ACK.
// Both PS/2 lines are open-drain; the *_low outputs pull the pad low when 1.
//
// Handshake: i_tx_data is taken on a cycle where i_tx_valid && o_tx_ready are
// both 1. o_tx_ready is high only in IDLE, so a request held while busy is
// simply not taken. o_done pulses for one cycle at the end of a transaction,
// and o_ack_err/o_timeout are meaningful in that cycle.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_dat_in,
  output logic       o_ps2_clk_low,
  output logic       o_ps2_dat_low,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic       o_timeout,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SHIFT     = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  // Last inhibit cycle, and the cycle before it where the start bit is loaded
  // so that the registered data output is low on the last inhibit cycle.
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);

  // Synchroniser and filter state
  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall;

  // FSM and datapath registers
  state_t        r_state, w_state_next;
  logic [IW-1:0] r_cnt, w_cnt_next;
  logic [WW-1:0] r_wd, w_wd_next;
  logic [3:0]    r_n, w_n_next;
  logic [3:0]    w_n_inc;
  logic [7:0]    r_data, w_data_next;
  logic          r_parity, w_parity_next;
  logic          r_dat_low, w_dat_low_next;
  logic          r_ack_err, w_ack_err_next;
  logic          r_timeout, w_timeout_next;

  // Two-flop synchronisers; idle (released) lines read high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_dat_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Clock filter: flip only after FILTER_LEN consecutive differing samples;
  // r_fall strobes for one cycle when the filtered clock goes 1 -> 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FLT_LAST) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
        r_fall     <= r_clk_filt;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wd      <= '0;
      r_n       <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_dat_low <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_wd      <= w_wd_next;
      r_n       <= w_n_next;
      r_data    <= w_data_next;
      r_parity  <= w_parity_next;
      r_dat_low <= w_dat_low_next;
      r_ack_err <= w_ack_err_next;
      r_timeout <= w_timeout_next;
    end
  end

  // Next-state logic: request sequence, bit shifting on filtered falls, watchdog.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_wd_next      = '0;
    w_n_next       = r_n;
    w_n_inc        = r_n + 4'd1;
    w_data_next    = r_data;
    w_parity_next  = r_parity;
    w_dat_low_next = r_dat_low;
    w_ack_err_next = r_ack_err;
    w_timeout_next = r_timeout;
    case (r_state)
      S_IDLE: begin
        w_dat_low_next = 1'b0;
        if (i_tx_valid) begin
          w_data_next    = i_tx_data;
          w_parity_next  = ~^i_tx_data;
          w_ack_err_next = 1'b0;
          w_timeout_next = 1'b0;
          w_cnt_next     = '0;
          w_state_next   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == INH_START) w_dat_low_next = 1'b1;
        if (r_cnt == INH_LAST) begin
          w_dat_low_next = 1'b1;
          w_state_next   = S_REQ;
        end
      end
      S_REQ: begin
        // Clock released, start bit held; watchdog runs from this cycle.
        w_dat_low_next = 1'b1;
        w_n_next       = '0;
        w_wd_next      = r_wd + 1'b1;
        w_state_next   = S_SHIFT;
      end
      S_SHIFT: begin
        w_wd_next = r_wd + 1'b1;
        if (r_wd == WD_LAST) begin
          w_dat_low_next = 1'b0;
          w_timeout_next = 1'b1;
          w_ack_err_next = 1'b0;
          w_wd_next      = '0;
          w_state_next   = S_DONE;
        end else if (r_fall) begin
          w_n_next = w_n_inc;
          if (w_n_inc <= 4'd8) begin
            // Bit n-1 is r_n, since r_n holds n-1 before the increment.
            w_dat_low_next = ~r_data[r_n[2:0]];
          end else if (w_n_inc == 4'd9) begin
            w_dat_low_next = ~r_parity;
          end else if (w_n_inc == 4'd10) begin
            w_dat_low_next = 1'b0;
          end else begin
            // ACK slot: device pulls data low on success.
            w_dat_low_next = 1'b0;
            w_ack_err_next = r_dat_s2;
            w_wd_next      = '0;
            w_state_next   = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_dat_low_next = 1'b0;
        if (r_clk_s2 && r_dat_s2) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_dat_low_next = 1'b0;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_dat_low_next = 1'b0;
        w_state_next   = S_IDLE;
      end
    endcase
  end

  assign o_tx_ready    = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_ps2_clk_low = (r_state == S_INHIBIT);
  assign o_ps2_dat_low = r_dat_low;
  assign o_ack_err     = r_ack_err;
  assign o_timeout     = r_timeout;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx with a simple PS/2 device model.
// Timing parameters are scaled down so the whole run stays short.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int TMO  = 3000;
  localparam int FLT  = 8;
  localparam int HALF = 40;

  logic       i_clk;
  logic       i_reset;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_ps2_clk_low;
  logic       o_ps2_dat_low;
  logic       o_busy;
  logic       o_done;
  logic       o_ack_err;
  logic       o_timeout;
  logic [2:0] o_dbg_state;

  logic dev_clk_low;
  logic dev_dat_low;
  wire  w_clk_line = ~(o_ps2_clk_low | dev_clk_low);
  wire  w_dat_line = ~(o_ps2_dat_low | dev_dat_low);

  int n_checks;
  int n_fail;
  int cyc;
  int done_cnt;
  int done_seen;
  int done_cyc;
  int req_cyc;
  logic done_ack, done_to, done_clk_low, done_dat_low;
  logic [0:0] exp_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_tx_data    (i_tx_data),
    .i_tx_valid   (i_tx_valid),
    .o_tx_ready   (o_tx_ready),
    .i_ps2_clk_in (w_clk_line),
    .i_ps2_dat_in (w_dat_line),
    .o_ps2_clk_low(o_ps2_clk_low),
    .o_ps2_dat_low(o_ps2_dat_low),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_ack_err    (o_ack_err),
    .o_timeout    (o_timeout),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and cycle counter
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Done monitor: counts pulse cycles and captures the result flags
  initial done_cnt = 0;
  always @(negedge i_clk) begin
    if (o_done) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cyc;
      done_ack     <= o_ack_err;
      done_to      <= o_timeout;
      done_clk_low <= o_ps2_clk_low;
      done_dat_low <= o_ps2_dat_low;
    end
  end

  // Global time limit
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1, "simulation time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Expected line levels at the device's rising edges: data LSB first, parity, stop.
  task automatic push_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(p);
    exp_q.push_back(1'b1);
  endtask

  // Accept a byte and measure the inhibit phase up to the REQ cycle.
  task automatic send(input logic [7:0] d);
    int n;
    logic prev, last;
    n = 0;
    while (!o_tx_ready && n < 200) begin
      n++;
      cyc_wait(1);
    end
    check_eq("ready_before_send", o_tx_ready, 1);
    i_tx_data  = d;
    i_tx_valid = 1'b1;
    cyc_wait(1);
    i_tx_valid = 1'b0;
    check_eq("accept_ready_low", o_tx_ready, 0);
    check_eq("accept_busy", o_busy, 1);
    n = 0;
    prev = 1'b0;
    last = 1'b0;
    while (o_ps2_clk_low === 1'b1 && n < INH + 100) begin
      prev = last;
      last = o_ps2_dat_low;
      n++;
      cyc_wait(1);
    end
    check_eq("inhibit_len", n, INH);
    check_eq("start_on_last_inhibit", last, 1);
    check_eq("dat_free_before_start", prev, 0);
    req_cyc = cyc;
    check_eq("req_dat_low", o_ps2_dat_low, 1);
    check_eq("req_state", o_dbg_state, 3'd2);
  endtask

  // Device clocks nfalls bits; samples data before each rise; optional ACK and glitches.
  task automatic dev_clock(input int nfalls, input logic ack, input logic glitch);
    logic [0:0] e;
    cyc_wait(20);
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11 && ack) begin
        dev_dat_low = 1'b1;
        cyc_wait(5);
      end
      dev_clk_low = 1'b1;
      cyc_wait(HALF);
      if (k <= 10 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq($sformatf("frame_bit%0d", k), w_dat_line, e);
      end
      dev_clk_low = 1'b0;
      if (k == 11) begin
        cyc_wait(5);
        dev_dat_low = 1'b0;
        cyc_wait(HALF - 5);
      end else if (glitch && (k == 3 || k == 6)) begin
        cyc_wait(10);
        dev_clk_low = 1'b1;
        cyc_wait(3);
        dev_clk_low = 1'b0;
        cyc_wait(HALF - 13);
      end else begin
        cyc_wait(HALF);
      end
    end
  endtask

  task automatic expect_done(input logic ack, input logic to);
    int n;
    n = 0;
    while (done_cnt == done_seen && n < 5000) begin
      n++;
      cyc_wait(1);
    end
    check_eq("done_seen", (done_cnt != done_seen), 1);
    check_eq("done_ack_err", done_ack, ack);
    check_eq("done_timeout", done_to, to);
    check_eq("done_clk_released", done_clk_low, 0);
    check_eq("done_dat_released", done_dat_low, 0);
    cyc_wait(3);
    check_eq("done_single_pulse", done_cnt - done_seen, 1);
    check_eq("idle_ready_after_done", o_tx_ready, 1);
    done_seen = done_cnt;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    done_seen   = 0;
    req_cyc     = 0;
    i_reset     = 1'b1;
    i_tx_valid  = 1'b0;
    i_tx_data   = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    cyc_wait(3);
    check_eq("rst_ready", o_tx_ready, 1);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_ack_err", o_ack_err, 0);
    check_eq("rst_timeout", o_timeout, 0);
    check_eq("rst_clk_low", o_ps2_clk_low, 0);
    check_eq("rst_dat_low", o_ps2_dat_low, 0);
    i_reset = 1'b0;
    cyc_wait(2);

    // 0xED: six ones, parity 1; device ACKs
    push_frame(8'hED, 1'b1);
    send(8'hED);
    dev_clock(11, 1'b1, 1'b0);
    check_eq("ed_queue_empty", exp_q.size(), 0);
    expect_done(1'b0, 1'b0);

    // 0x01 parity 0, 0xFF parity 1
    push_frame(8'h01, 1'b0);
    send(8'h01);
    dev_clock(11, 1'b1, 1'b0);
    expect_done(1'b0, 1'b0);
    push_frame(8'hFF, 1'b1);
    send(8'hFF);
    dev_clock(11, 1'b1, 1'b0);
    expect_done(1'b0, 1'b0);

    // No ACK from device: 0x3C has four ones, parity 1
    push_frame(8'h3C, 1'b1);
    send(8'h3C);
    dev_clock(11, 1'b0, 1'b0);
    expect_done(1'b1, 1'b0);

    // Device never clocks: watchdog
    send(8'h55);
    expect_done(1'b0, 1'b1);
    check_eq("timeout_latency", done_cyc - req_cyc, TMO);

    // Reset after the 4th data bit, with tx_valid in the same cycle
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    send(8'h5A);
    dev_clock(4, 1'b0, 1'b0);
    check_eq("mid_busy", o_busy, 1);
    i_reset    = 1'b1;
    i_tx_valid = 1'b1;
    i_tx_data  = 8'h77;
    cyc_wait(1);
    check_eq("midrst_ready", o_tx_ready, 1);
    check_eq("midrst_busy", o_busy, 0);
    check_eq("midrst_clk_low", o_ps2_clk_low, 0);
    check_eq("midrst_dat_low", o_ps2_dat_low, 0);
    i_reset    = 1'b0;
    i_tx_valid = 1'b0;
    cyc_wait(20);
    check_eq("midrst_no_done", done_cnt - done_seen, 0);
    check_eq("midrst_still_idle", o_tx_ready, 1);
    push_frame(8'hF4, 1'b0);
    send(8'hF4);
    dev_clock(11, 1'b1, 1'b0);
    expect_done(1'b0, 1'b0);

    // Clock glitches during SHIFT and tx_valid while busy; 0xA7 has five ones, parity 0
    push_frame(8'hA7, 1'b0);
    send(8'hA7);
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b1;
    cyc_wait(2);
    i_tx_valid = 1'b0;
    check_eq("busy_valid_ignored", o_tx_ready, 0);
    dev_clock(11, 1'b1, 1'b1);
    check_eq("glitch_queue_empty", exp_q.size(), 0);
    expect_done(1'b0, 1'b0);
    cyc_wait(20);
    check_eq("no_phantom_clk", o_ps2_clk_low, 0);
    check_eq("no_phantom_ready", o_tx_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
